// File: rtl/intmul_pkg.sv
// Shared types and helpers for the multiplier arbiter: requester tag carried
// alongside the multiplier pipeline and the credit counter width.
package intmul_pkg;

    localparam int unsigned N_REQ_DFLT = 4;
    localparam int unsigned W_ID       = $clog2(N_REQ_DFLT);

    typedef struct packed {
        logic            valid;
        logic [W_ID-1:0] id;
    } tag_t;

    // Credit must reach FIFO_DEPTH itself, hence the extra bit.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/intmul_result_fifo.sv
// Synchronous result FIFO; read data is forced to zero while empty so the
// consumer-side outputs have a defined idle value.
module intmul_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/intmul_arbiter.sv
// Round-robin front end sharing one non-stallable pipelined multiplier among
// N_REQ requesters; credits bound in-flight plus buffered results to the FIFO size.
module intmul_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned W_A        = 64,
    parameter int unsigned W_B        = 64,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned W_ID       = intmul_pkg::W_ID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*W_A-1:0]   req_a,
    input  logic [N_REQ*W_B-1:0]   req_b,
    output logic [W_A-1:0]         mul_a,
    output logic [W_B-1:0]         mul_b,
    input  logic [W_A+W_B-1:0]     mul_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W_A+W_B-1:0]     rsp_c,
    output logic [W_ID-1:0]        rsp_id,
    output logic                   busy
);
    import intmul_pkg::*;

    localparam int unsigned W_CR = credit_width(FIFO_DEPTH);
    localparam int unsigned W_P  = W_A + W_B;

    logic [W_ID-1:0]     ptr_q;
    logic [W_ID-1:0]     grant;
    logic [W_ID-1:0]     idx;
    logic                any_valid;
    logic                issue;
    logic                pop;
    logic [W_CR-1:0]     credit_q;
    logic [W_A-1:0]      sel_a;
    logic [W_B-1:0]      sel_b;
    tag_t                tag_q [MUL_LAT+1];
    logic                fifo_empty;
    logic                fifo_full;
    logic [W_P+W_ID-1:0] fifo_dout;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            idx = W_ID'((32'(ptr_q) + j) % N_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == W_ID'(i)) begin
                sel_a = req_a[i*W_A +: W_A];
                sel_b = req_b[i*W_B +: W_B];
            end
        end
    end

    assign issue = any_valid && (credit_q < W_CR'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[grant] = 1'b1;
    end

    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = !fifo_empty;
    assign busy      = (credit_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            credit_q <= '0;
            for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            mul_a          <= issue ? sel_a : '0;
            mul_b          <= issue ? sel_b : '0;
            tag_q[0].valid <= issue;
            tag_q[0].id    <= grant;
            for (int i = 1; i <= MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (issue) ptr_q <= (grant == W_ID'(N_REQ - 1)) ? '0 : grant + 1'b1;
            if (issue && !pop) begin
                credit_q <= credit_q + 1'b1;
            end else if (!issue && pop) begin
                credit_q <= credit_q - 1'b1;
            end
        end
    end

    // Credits already keep the FIFO from filling; the full gate is a backstop.
    intmul_result_fifo #(
        .WIDTH (W_P + W_ID),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (tag_q[MUL_LAT].valid && !fifo_full),
        .din   ({mul_c, tag_q[MUL_LAT].id}),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rsp_c  = fifo_dout[W_P+W_ID-1:W_ID];
    assign rsp_id = fifo_dout[W_ID-1:0];

endmodule

// File: tb/tb_intmul_arbiter.sv
// Directed bench for intmul_arbiter with a behavioural LAT-stage multiplier attached.
module tb_intmul_arbiter;

    localparam int unsigned N_REQ      = 4;
    localparam int unsigned W_A        = 64;
    localparam int unsigned W_B        = 64;
    localparam int unsigned MUL_LAT    = 4;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned W_ID       = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*W_A-1:0] req_a;
    logic [N_REQ*W_B-1:0] req_b;
    logic [W_A-1:0]       mul_a;
    logic [W_B-1:0]       mul_b;
    logic [W_A+W_B-1:0]   mul_c;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W_A+W_B-1:0]   rsp_c;
    logic [W_ID-1:0]      rsp_id;
    logic                 busy;

    intmul_arbiter #(
        .N_REQ      (N_REQ),
        .W_A        (W_A),
        .W_B        (W_B),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .W_ID       (W_ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: LAT register stages, never stalls.
    logic [127:0] mpipe [MUL_LAT];
    initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
    always @(posedge clk) begin
        mpipe[0] <= 128'(mul_a) * 128'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_c = mpipe[MUL_LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake and response logs, sampled mid-cycle.
    int           hs_cnt = 0;
    int           hs_id_q [$];
    logic [127:0] hs_prod_q [$];
    int           rsp_id_q [$];
    logic [127:0] rsp_c_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_cnt++;
                    hs_id_q.push_back(i);
                    hs_prod_q.push_back(128'(req_a[i*W_A +: W_A]) * 128'(req_b[i*W_B +: W_B]));
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_c_q.push_back(rsp_c);
                rsp_id_q.push_back(int'(rsp_id));
            end
        end
    end

    function automatic void clear_logs();
        hs_cnt = 0;
        hs_id_q.delete();
        hs_prod_q.delete();
        rsp_id_q.delete();
        rsp_c_q.delete();
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Called just after the handshake edge; counts edges until rsp_valid shows.
    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 30) begin
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && n < 80) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, {127'b0, busy}, 128'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int lat;
    int bubbles;
    int seen;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: idle after reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("t1_req_ready", 128'(req_ready), 128'd0);
        check_eq("t1_rsp_valid", 128'(rsp_valid), 128'd0);
        check_eq("t1_busy", 128'(busy), 128'd0);
        check_eq("t1_mul_a", 128'(mul_a), 128'd0);
        check_eq("t1_mul_b", 128'(mul_b), 128'd0);
        check_eq("t1_rsp_c", rsp_c, 128'd0);
        check_eq("t1_rsp_id", 128'(rsp_id), 128'd0);

        // 2: single max-value request, latency and full-width product
        @(posedge clk); #1;
        clear_logs();
        req_a[63:0] = '1;
        req_b[63:0] = '1;
        req_valid   = 4'b0001;
        @(negedge clk);
        check_eq("t2_ready", 128'(req_ready), 128'd1);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(lat);
        check_eq("t2_latency", 128'(lat), 128'(MUL_LAT + 1));
        check_eq("t2_rsp_c", rsp_c, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check_eq("t2_rsp_id", 128'(rsp_id), 128'd0);
        drain("t2_drain");

        // 3: all requesters valid, round-robin from ptr 0
        do_reset();
        clear_logs();
        req_a     = {64'd4, 64'd3, 64'd2, 64'd1};
        req_b     = {4{64'h100}};
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_eq("t3_grant", 128'(req_ready), 128'(4'b0001 << (n % 4)));
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain("t3_drain");
        check_eq("t3_count", 128'(rsp_c_q.size()), 128'd8);
        for (int n = 0; n < rsp_c_q.size(); n++) begin
            check_eq("t3_rsp_id", 128'(rsp_id_q[n]), 128'(n % 4));
            check_eq("t3_rsp_c", rsp_c_q[n], 128'((n % 4 + 1) * 256));
        end

        // 4: consumer stalled, credits cap issue at FIFO_DEPTH
        @(posedge clk); #1;
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        repeat (20) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("t4_hs_count", 128'(hs_cnt), 128'(FIFO_DEPTH));
        check_eq("t4_ready_zero", 128'(req_ready), 128'd0);
        check_eq("t4_busy", 128'(busy), 128'd1);
        check_eq("t4_rsp_valid", 128'(rsp_valid), 128'd1);
        check_eq("t4_head_c", rsp_c, 128'd256);
        check_eq("t4_head_id", 128'(rsp_id), 128'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        drain("t4_drain");
        check_eq("t4_resume", 128'(hs_cnt > int'(FIFO_DEPTH)), 128'd1);
        check_eq("t4_count", 128'(rsp_c_q.size()), 128'(hs_cnt));
        for (int n = 0; n < rsp_c_q.size(); n++) begin
            check_eq("t4_rsp_id", 128'(rsp_id_q[n]), 128'(n % 4));
            check_eq("t4_rsp_c", rsp_c_q[n], 128'((n % 4 + 1) * 256));
        end

        // 5: 100 cycles of back-to-back random operands
        @(posedge clk); #1;
        clear_logs();
        bubbles = 0;
        for (int n = 0; n < 100; n++) begin
            req_a = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            req_b = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            req_valid = 4'hF;
            @(negedge clk);
            if ((req_valid & req_ready) == '0) bubbles++;
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain("t5_drain");
        check_eq("t5_bubbles", 128'(bubbles), 128'd0);
        check_eq("t5_hs_count", 128'(hs_cnt), 128'd100);
        check_eq("t5_rsp_count", 128'(rsp_c_q.size()), 128'd100);
        for (int n = 0; n < rsp_c_q.size() && n < hs_prod_q.size(); n++) begin
            check_eq("t5_grant_rr", 128'(hs_id_q[n]), 128'((hs_id_q[0] + n) % 4));
            check_eq("t5_rsp_id", 128'(rsp_id_q[n]), 128'(hs_id_q[n]));
            check_eq("t5_rsp_c", rsp_c_q[n], hs_prod_q[n]);
        end

        // 6: reset with products in flight, then a clean single request
        do_reset();
        req_a       = '0;
        req_b       = '0;
        req_a[63:0] = 64'd5;
        req_b[63:0] = 64'd7;
        req_valid   = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("t6_issue", 128'(req_ready), 128'd1);
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_logs();
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_eq("t6_no_rsp", 128'(seen), 128'd0);
        check_eq("t6_busy", 128'(busy), 128'd0);
        check_eq("t6_rsp_c_idle", rsp_c, 128'd0);
        @(posedge clk); #1;
        req_a[191:128] = 64'h1_0000_0001;
        req_b[191:128] = 64'h1_0000_0001;
        req_valid      = 4'b0100;
        @(negedge clk);
        check_eq("t6_ready", 128'(req_ready), 128'(4'b0100));
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(lat);
        check_eq("t6_latency", 128'(lat), 128'(MUL_LAT + 1));
        check_eq("t6_rsp_c", rsp_c, 128'h1_0000_0002_0000_0001);
        check_eq("t6_rsp_id", 128'(rsp_id), 128'd2);
        drain("t6_drain");
        check_eq("t6_rsp_count", 128'(rsp_c_q.size()), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
